systolic_sequencer: RTL and testbench

- Parametrised controller that runs one matrix multiply C[MxN] = A[MxK] x B[KxN] on the systolic array.
- Accepts operand slices over a valid/ready stream and skews them per lane into the array edges.
- Clears, flushes and drains the array, then returns result rows over a second valid/ready stream with a done pulse.
- Sits between the operand caches and the array inside the TPU top.

---
 rtl/systolic_sequencer.sv | 171 +++++++++++++++++
 tb/tb_systolic_sequencer.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_sequencer.sv
// Sequencer for one C = A x B job on the systolic array.
// Ports: start/sizes, operand stream in, skewed edges out, result stream out, status.
module systolic_sequencer #(
  parameter int ROW_NUMBER    = 4,
  parameter int COLUMN_NUMBER = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int ACC_WIDTH     = 8,
  parameter int DIM_WIDTH     = 8
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              start,
  input  logic [DIM_WIDTH-1:0]              size_row_A,
  input  logic [DIM_WIDTH-1:0]              size_column_B,
  input  logic [DIM_WIDTH-1:0]              size_columnrow_AB,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [ROW_NUMBER*DATA_WIDTH-1:0]  in_a,
  input  logic [COLUMN_NUMBER*DATA_WIDTH-1:0] in_b,
  output logic [ROW_NUMBER*DATA_WIDTH-1:0]  left_in,
  output logic [COLUMN_NUMBER*DATA_WIDTH-1:0] top_in,
  output logic                              array_reset,
  output logic                              through,
  input  logic [COLUMN_NUMBER*ACC_WIDTH-1:0] down_out,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic [COLUMN_NUMBER*ACC_WIDTH-1:0] res_data,
  output logic [DIM_WIDTH-1:0]              res_row,
  output logic                              res_last,
  output logic                              busy,
  output logic                              done,
  output logic                              err,
  output logic [31:0]                       cycle_count
);

  localparam int DCW = $clog2(ROW_NUMBER) + 1;
  localparam int FL  = ROW_NUMBER + COLUMN_NUMBER - 1;
  localparam int FCW = $clog2(FL + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t               st;
  logic [DIM_WIDTH-1:0] m_q;
  logic [DIM_WIDTH-1:0] n_q;
  logic [DIM_WIDTH-1:0] k_q;
  logic [DIM_WIDTH-1:0] kcnt;
  logic [FCW-1:0]       fcnt;
  logic [DCW-1:0]       dcnt;
  logic                 size_bad;
  logic                 feed_hs;
  logic                 drain_hs;
  logic                 last_row;

  assign size_bad =
    (size_row_A == '0) ||
    (size_column_B == '0) ||
    (size_columnrow_AB == '0) ||
    (size_row_A > DIM_WIDTH'(ROW_NUMBER)) ||
    (size_column_B > DIM_WIDTH'(COLUMN_NUMBER));

  assign feed_hs  = (st == S_FEED) && in_valid;
  assign drain_hs = (st == S_DRAIN) && res_ready;
  assign last_row = (dcnt == DCW'(ROW_NUMBER - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st          <= S_IDLE;
      m_q         <= '0;
      n_q         <= '0;
      k_q         <= '0;
      kcnt        <= '0;
      fcnt        <= '0;
      dcnt        <= '0;
      err         <= 1'b0;
      cycle_count <= '0;
    end else begin
      unique case (st)
        S_IDLE: begin
          if (start) begin
            m_q  <= size_row_A;
            n_q  <= size_column_B;
            k_q  <= size_columnrow_AB;
            kcnt <= '0;
            fcnt <= '0;
            dcnt <= '0;
            err  <= size_bad;
            // the accepting cycle is counted as the first
            cycle_count <= 32'd1;
            st <= size_bad ? S_DONE : S_CLEAR;
          end
        end
        S_CLEAR: st <= S_FEED;
        S_FEED: begin
          if (feed_hs) begin
            kcnt <= kcnt + 1'b1;
            if (kcnt == k_q - 1'b1)
              st <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          fcnt <= fcnt + 1'b1;
          if (fcnt == FCW'(FL - 1))
            st <= S_DRAIN;
        end
        S_DRAIN: begin
          if (drain_hs) begin
            dcnt <= dcnt + 1'b1;
            if (last_row)
              st <= S_DONE;
          end
        end
        S_DONE: st <= S_IDLE;
        default: st <= S_IDLE;
      endcase
      if (st != S_IDLE && cycle_count != '1)
        cycle_count <= cycle_count + 32'd1;
    end
  end

  assign in_ready    = (st == S_FEED);
  assign array_reset = !reset_n || (st == S_CLEAR);
  assign busy        = (st != S_IDLE);
  assign done        = (st == S_DONE);
  assign res_valid   = (st == S_DRAIN);
  assign through     = res_valid && res_ready;
  assign res_data    = res_valid ? down_out : '0;
  assign res_last    = res_valid && last_row;
  assign res_row     = res_valid ?
    DIM_WIDTH'(ROW_NUMBER - 1) - DIM_WIDTH'(dcnt) : '0;

  // lane i of A is delayed i+1 cycles; idle cycles feed zero bubbles
  for (genvar i = 0; i < ROW_NUMBER; i++) begin : g_a
    logic [DATA_WIDTH-1:0] sr [i+1];
    logic [DATA_WIDTH-1:0] src;
    assign src = (feed_hs && DIM_WIDTH'(i) < m_q) ?
      in_a[i*DATA_WIDTH +: DATA_WIDTH] : '0;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int s = 0; s <= i; s++) sr[s] <= '0;
      end else begin
        sr[0] <= src;
        for (int s = 1; s <= i; s++) sr[s] <= sr[s-1];
      end
    end
    assign left_in[i*DATA_WIDTH +: DATA_WIDTH] = sr[i];
  end

  for (genvar j = 0; j < COLUMN_NUMBER; j++) begin : g_b
    logic [DATA_WIDTH-1:0] sr [j+1];
    logic [DATA_WIDTH-1:0] src;
    assign src = (feed_hs && DIM_WIDTH'(j) < n_q) ?
      in_b[j*DATA_WIDTH +: DATA_WIDTH] : '0;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int s = 0; s <= j; s++) sr[s] <= '0;
      end else begin
        sr[0] <= src;
        for (int s = 1; s <= j; s++) sr[s] <= sr[s-1];
      end
    end
    assign top_in[j*DATA_WIDTH +: DATA_WIDTH] = sr[j];
  end

endmodule

// File: tb/tb_systolic_sequencer.sv
// Bench for systolic_sequencer with a behavioural output-stationary array.
// Results are checked against a plain matrix-product reference.
module tb_systolic_sequencer;

  localparam int R = 4;
  localparam int C = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  size_row_A;
  logic [7:0]  size_column_B;
  logic [7:0]  size_columnrow_AB;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] left_in;
  logic [31:0] top_in;
  logic        array_reset;
  logic        through;
  logic [31:0] down_out;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [7:0]  res_row;
  logic        res_last;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] cycle_count;

  int checks = 0;
  int errors = 0;

  int A [R][16];
  int B [16][C];

  always #5 clk = ~clk;

  systolic_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .size_row_A(size_row_A),
    .size_column_B(size_column_B),
    .size_columnrow_AB(size_columnrow_AB),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .left_in(left_in), .top_in(top_in),
    .array_reset(array_reset), .through(through),
    .down_out(down_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_row(res_row),
    .res_last(res_last), .busy(busy), .done(done),
    .err(err), .cycle_count(cycle_count)
  );

  // output-stationary array: a moves right, b moves down
  logic [7:0] acc [R][C];
  logic [7:0] ar  [R][C];
  logic [7:0] br  [R][C];

  always @(posedge clk) begin
    logic [7:0] a_in;
    logic [7:0] b_in;
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++) begin
        if (array_reset) begin
          acc[i][j] <= '0;
          ar[i][j]  <= '0;
          br[i][j]  <= '0;
        end else if (through) begin
          acc[i][j] <= (i == 0) ? 8'd0 : acc[i-1][j];
        end else begin
          a_in = (j == 0) ? left_in[i*8 +: 8] : ar[i][j-1];
          b_in = (i == 0) ? top_in[j*8 +: 8] : br[i-1][j];
          acc[i][j] <= 8'(acc[i][j] + a_in * b_in);
          ar[i][j]  <= a_in;
          br[i][j]  <= b_in;
        end
      end
  end

  always_comb begin
    down_out = '0;
    for (int j = 0; j < C; j++)
      down_out[j*8 +: 8] = acc[R-1][j];
  end

  function automatic logic [31:0] exp_row(
    int m, int n, int k, int r);
    logic [31:0] v;
    v = '0;
    for (int j = 0; j < C; j++) begin
      int s;
      s = 0;
      if (r < m && j < n)
        for (int q = 0; q < k; q++)
          s += A[r][q] * B[q][j];
      v[j*8 +: 8] = 8'(s);
    end
    return v;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < R; i++)
      for (int q = 0; q < 16; q++)
        A[i][q] = int'($urandom_range(0, 255));
    for (int q = 0; q < 16; q++)
      for (int j = 0; j < C; j++)
        B[q][j] = int'($urandom_range(0, 255));
  endtask

  task automatic fill_identity();
    for (int i = 0; i < R; i++)
      for (int q = 0; q < 16; q++)
        A[i][q] = (i == q) ? 1 : 0;
    for (int q = 0; q < 16; q++)
      for (int j = 0; j < C; j++)
        B[q][j] = (q * 4 + j) & 255;
  endtask

  task automatic drive_slice(int k);
    in_valid = 1'b1;
    for (int i = 0; i < R; i++)
      in_a[i*8 +: 8] = 8'(A[i][k]);
    for (int j = 0; j < C; j++)
      in_b[j*8 +: 8] = 8'(B[k][j]);
  endtask

  // vmode 1: in_valid low on the first and every other FEED cycle
  task automatic run_job(int m, int n, int k,
                         int vmode, bit bp, bit exp_err);
    int  kk, rows, stall, feed_i;
    int  last_cyc, done_cyc, exp_cc;
    bit  saw_ready, saw_clr;
    logic [31:0] ev;
    kk = 0; rows = 0; stall = 0; feed_i = 0;
    last_cyc = -1; done_cyc = -1;
    saw_ready = 0; saw_clr = 0;
    @(negedge clk);
    start = 1'b1;
    size_row_A = 8'(m);
    size_column_B = 8'(n);
    size_columnrow_AB = 8'(k);
    res_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc < 600; cyc++) begin
      if (cyc > 1) @(negedge clk);
      in_valid = 1'b0;
      in_a = '0;
      in_b = '0;
      if (in_ready) begin
        saw_ready = 1;
        feed_i++;
        if ((vmode == 0 || feed_i % 2 == 0) && kk < k) begin
          drive_slice(kk);
          kk++;
        end
      end
      if (array_reset) saw_clr = 1;
      res_ready = 1'b1;
      if (bp && rows == 1 && stall < 3) res_ready = 1'b0;
      #1;
      if (res_valid && rows >= R) begin
        checks++;
        errors++;
        $display("FAIL extra_row got row %0d", res_row);
      end else if (!res_ready) begin
        stall++;
        ev = exp_row(m, n, k, R - 1 - rows);
        checks++;
        if (res_valid !== 1'b1 || through !== 1'b0) begin
          errors++;
          $display("FAIL stall_hold valid=%b through=%b req 1/0",
                   res_valid, through);
        end
        checks++;
        if (res_data !== ev || res_row !== 8'(R-1-rows)) begin
          errors++;
          $display("FAIL stall_data got %h/%0d req %h/%0d",
                   res_data, res_row, ev, R - 1 - rows);
        end
      end else if (res_valid) begin
        ev = exp_row(m, n, k, R - 1 - rows);
        checks++;
        if (res_row !== 8'(R - 1 - rows)) begin
          errors++;
          $display("FAIL res_row got %0d req %0d",
                   res_row, R - 1 - rows);
        end
        checks++;
        if (res_data !== ev) begin
          errors++;
          $display("FAIL res_data row %0d got %h req %h",
                   R - 1 - rows, res_data, ev);
        end
        checks++;
        if (res_last !== (rows == R - 1) || through !== 1'b1) begin
          errors++;
          $display("FAIL last_through got %b/%b req %b/1",
                   res_last, through, rows == R - 1);
        end
        if (rows == R - 1) last_cyc = cyc;
        rows++;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
    in_valid = 1'b0;
    res_ready = 1'b1;
    checks++;
    if (done_cyc < 0) begin
      errors++;
      $display("FAIL done_timeout no done seen");
    end
    if (exp_err) exp_cc = 2;
    else exp_cc = 3 + (vmode == 0 ? k : 2 * k)
                  + (R + C - 1) + R + (bp ? 3 : 0);
    if (!exp_err) begin
      checks++;
      if (done_cyc != last_cyc + 1 || rows != R) begin
        errors++;
        $display("FAIL done_timing done %0d last %0d rows %0d req rows %0d",
                 done_cyc, last_cyc, rows, R);
      end
    end
    checks++;
    if (saw_ready !== !exp_err || saw_clr !== !exp_err) begin
      errors++;
      $display("FAIL ready_clear got %b/%b req %b",
               saw_ready, saw_clr, !exp_err);
    end
    @(negedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_done done=%b busy=%b req 0/0", done, busy);
    end
    checks++;
    if (cycle_count !== 32'(exp_cc)) begin
      errors++;
      $display("FAIL cycle_count got %0d req %0d", cycle_count, exp_cc);
    end
    checks++;
    if (err !== exp_err) begin
      errors++;
      $display("FAIL err got %b req %b", err, exp_err);
    end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (cycle_count !== 32'(exp_cc) || err !== exp_err) begin
      errors++;
      $display("FAIL hold_status cc %0d err %b req %0d %b",
               cycle_count, err, exp_cc, exp_err);
    end
  endtask

  task automatic check_reset_outputs(string tag);
    checks++;
    if ({in_ready, through, res_valid, res_last, busy, done, err}
        !== 7'd0 || left_in !== '0 || top_in !== '0 ||
        res_data !== '0 || res_row !== '0 || cycle_count !== '0) begin
      errors++;
      $display("FAIL %s outputs not all zero rdy=%b busy=%b cc=%0d",
               tag, in_ready, busy, cycle_count);
    end
    checks++;
    if (array_reset !== 1'b1) begin
      errors++;
      $display("FAIL %s array_reset got %b req 1", tag, array_reset);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (array_reset !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL after_reset clr=%b busy=%b req 0/0",
               array_reset, busy);
    end
  endtask

  task automatic test_identity();
    fill_identity();
    run_job(4, 4, 4, 0, 0, 0);
  endtask

  task automatic test_alt_valid();
    fill_identity();
    run_job(4, 4, 4, 1, 0, 0);
  endtask

  task automatic test_mask();
    for (int i = 0; i < R; i++)
      for (int q = 0; q < 16; q++) A[i][q] = 1;
    for (int q = 0; q < 16; q++)
      for (int j = 0; j < C; j++) B[q][j] = 1;
    run_job(2, 3, 5, 0, 0, 0);
  endtask

  task automatic test_backpressure();
    fill_random();
    run_job(4, 4, 6, 0, 1, 0);
  endtask

  task automatic test_size_err();
    run_job(0, 4, 4, 0, 0, 1);
    run_job(4, 5, 4, 0, 0, 1);
    fill_random();
    run_job(3, 4, 3, 0, 0, 0);
  endtask

  task automatic test_reset_midjob();
    int  kk;
    bit  saw_done;
    fill_identity();
    kk = 0;
    saw_done = 0;
    @(negedge clk);
    start = 1'b1;
    size_row_A = 8'd4;
    size_column_B = 8'd4;
    size_columnrow_AB = 8'd4;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 20 && kk < 2; cyc++) begin
      in_valid = 1'b0;
      if (in_ready) begin
        drive_slice(kk);
        kk++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    checks++;
    if (kk != 2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midjob_feed slices %0d busy %b req 2/1", kk, busy);
    end
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midjob_reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    checks++;
    if (saw_done || busy !== 1'b0) begin
      errors++;
      $display("FAIL midjob_abandon done=%b busy=%b req 0/0",
               saw_done, busy);
    end
    run_job(4, 4, 4, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 4; t++) begin
      fill_random();
      run_job(int'($urandom_range(1, R)), int'($urandom_range(1, C)),
              int'($urandom_range(1, 12)), int'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 0);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    size_row_A = '0;
    size_column_B = '0;
    size_columnrow_AB = '0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    res_ready = 1'b1;
    test_reset();
    test_identity();
    test_alt_valid();
    test_mask();
    test_backpressure();
    test_size_err();
    test_reset_midjob();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
